design_ift_mux: RTL and testbench

//   Registered 2:1 multiplexer with information-flow-tracking (IFT) tag propagation.

---
 rtl/design_ift_mux.sv | 46 ++++
 tb/tb_design_ift_mux.sv | 123 ++++++++++++
 2 files changed

// File: rtl/design_ift_mux.sv
// Registered 2:1 mux with information-flow-tracking tag propagation.
// Output c follows the selected input; c_t collects the labels that can influence c.
module design_ift_mux #(
    parameter int TAG_W   = 32,
    parameter bit PRECISE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic [TAG_W-1:0] a_t,
    input  logic             b,
    input  logic [TAG_W-1:0] b_t,
    input  logic             s,
    input  logic [TAG_W-1:0] s_t,
    output logic             c,
    output logic [TAG_W-1:0] c_t
);

    logic             c_n;
    logic [TAG_W-1:0] dt;
    logic [TAG_W-1:0] st;
    logic [TAG_W-1:0] c_t_n;
    logic             sel_flows;

    // Next value and tag: selected input's tag, plus the select tag when s can matter.
    // In precise mode s only influences c when the two data inputs differ.
    always_comb begin
        c_n       = s ? b : a;
        dt        = s ? b_t : a_t;
        sel_flows = (PRECISE == 1'b0) || (a != b);
        st        = sel_flows ? s_t : '0;
        c_t_n     = dt | st;
    end

    // Output register; reset clears value and tag immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c   <= 1'b0;
            c_t <= '0;
        end else begin
            c   <= c_n;
            c_t <= c_t_n;
        end
    end

endmodule

// File: tb/tb_design_ift_mux.sv
// Directed bench for design_ift_mux.
// Drives precise and imprecise instances from the same inputs.
module tb_design_ift_mux;

    logic        clk;
    logic        rst_n;
    logic        a;
    logic        b;
    logic        s;
    logic [31:0] a_t;
    logic [31:0] b_t;
    logic [31:0] s_t;
    logic        c_p;
    logic [31:0] c_t_p;
    logic        c_i;
    logic [31:0] c_t_i;

    int checks = 0;
    int errors = 0;

    design_ift_mux #(.TAG_W(32), .PRECISE(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .a(a), .a_t(a_t), .b(b), .b_t(b_t), .s(s), .s_t(s_t),
        .c(c_p), .c_t(c_t_p)
    );

    design_ift_mux #(.TAG_W(32), .PRECISE(1'b0)) dut_i (
        .clk(clk), .rst_n(rst_n),
        .a(a), .a_t(a_t), .b(b), .b_t(b_t), .s(s), .s_t(s_t),
        .c(c_i), .c_t(c_t_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic both(input string tag, input logic ec,
                        input logic [31:0] et_p, input logic [31:0] et_i);
        chk({tag, "_c_p"}, {31'd0, c_p}, {31'd0, ec});
        chk({tag, "_ct_p"}, c_t_p, et_p);
        chk({tag, "_c_i"}, {31'd0, c_i}, {31'd0, ec});
        chk({tag, "_ct_i"}, c_t_i, et_i);
    endtask

    logic [7:0] exp_c;

    initial begin
        exp_c = 8'b1100_1010;
        rst_n = 1'b1;
        a = 1'b1; b = 1'b1; s = 1'b1;
        a_t = '1; b_t = '1; s_t = '1;
        #1 rst_n = 1'b0;
        #1;
        both("rst_async", 1'b0, 32'h0, 32'h0);
        step();
        both("rst_hold", 1'b0, 32'h0, 32'h0);

        a_t = '0; b_t = '0; s_t = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = i[0]; b = i[1]; s = i[2];
            step();
            both($sformatf("truth%0d", i), exp_c[i], 32'h0, 32'h0);
        end

        a = 1'b1; b = 1'b0; s = 1'b0;
        a_t = 32'h1; b_t = 32'h2; s_t = 32'h0;
        step();
        both("dflow_a", 1'b1, 32'h1, 32'h1);
        s = 1'b1;
        step();
        both("dflow_b", 1'b0, 32'h2, 32'h2);

        a = 1'b1; b = 1'b1; s = 1'b0;
        a_t = 32'h0; b_t = 32'h0; s_t = 32'h4;
        step();
        both("sel_eq", 1'b1, 32'h0, 32'h4);
        a = 1'b0;
        step();
        both("sel_ne", 1'b0, 32'h4, 32'h4);
        a = 1'b1; a_t = 32'h8;
        step();
        both("sel_or", 1'b1, 32'h8, 32'hC);

        a = 1'b0; b = 1'b1; s = 1'b0;
        a_t = 32'h10; b_t = 32'hFFFF_FFFF; s_t = 32'h0;
        step();
        both("unsel", 1'b0, 32'h10, 32'h10);
        #4;
        both("hold", 1'b0, 32'h10, 32'h10);

        a = 1'b1; b = 1'b0; s = 1'b0;
        a_t = 32'h20; b_t = 32'h0; s_t = 32'h40;
        step();
        both("stream", 1'b1, 32'h60, 32'h60);
        a = 1'b0; b = 1'b1; s = 1'b1; b_t = 32'h80;
        #2 rst_n = 1'b0;
        #1;
        both("mid_rst", 1'b0, 32'h0, 32'h0);
        #2 rst_n = 1'b1;
        #2;
        both("post_rel", 1'b0, 32'h0, 32'h0);
        step();
        both("resume", 1'b1, 32'hC0, 32'hC0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
